map_port_arbiter: RTL

//   Shares port B of the 4-bit map/candy BRAM (32x36 tiles, 1-cycle read latency)

---
 rtl/map_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/map_port_arbiter.sv
// Port-B arbiter for the map/candy tile BRAM: one tile writer and N_RD round-robin
// tile readers share a single access per clock, with a bounded write burst.
module map_port_arbiter #(
  parameter int N_RD         = 5,
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 4,
  parameter int WR_BURST_MAX = 4
) (
  input  logic                     vga_pix_clk,
  input  logic                     rst_n,
  input  logic                     frame_stb,
  input  logic [N_RD-1:0]          rd_req,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD-1:0]          rd_gnt,
  output logic [N_RD-1:0]          rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic                     bram_we,
  output logic [DATA_W-1:0]        bram_din,
  input  logic [DATA_W-1:0]        bram_dout
);

  localparam int PTR_W   = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int BURST_W = $clog2(WR_BURST_MAX + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(WR_BURST_MAX);

  logic [N_RD-1:0]    rd_gnt_q, rd_gnt_d;
  logic [N_RD-1:0]    rd_valid_q;
  logic [DATA_W-1:0]  rd_hold_q;
  logic               wr_ack_q, wr_ack_d;
  logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;
  logic               bram_we_q, bram_we_d;
  logic [DATA_W-1:0]  bram_din_q, bram_din_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  logic [N_RD-1:0]    rd_elig_s;
  logic               rd_pend_s;
  logic               wr_win_s;
  logic               rd_found_s;
  int                 rd_sel_s;

  // A reader whose grant is showing this cycle is still dropping its request, so mask it.
  assign rd_elig_s = rd_req & ~rd_gnt_q;
  assign rd_pend_s = |rd_elig_s;
  assign wr_win_s  = wr_req && ((burst_q < BURST_MAX) || !rd_pend_s);

  always_comb begin
    rd_found_s = 1'b0;
    rd_sel_s   = 0;
    for (int k = 0; k < N_RD; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= N_RD) begin
        idx = idx - N_RD;
      end else begin
        idx = idx;
      end
      if (!rd_found_s && rd_elig_s[idx]) begin
        rd_found_s = 1'b1;
        rd_sel_s   = idx;
      end else begin
        rd_found_s = rd_found_s;
      end
    end
  end

  always_comb begin
    rd_gnt_d    = '0;
    wr_ack_d    = 1'b0;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    rr_d        = rr_q;
    burst_d     = burst_q;
    if (wr_win_s) begin
      wr_ack_d    = 1'b1;
      bram_we_d   = 1'b1;
      bram_addr_d = wr_addr;
      bram_din_d  = wr_data;
      if (!rd_pend_s) begin
        burst_d = '0;
      end else if (burst_q < BURST_MAX) begin
        burst_d = burst_q + BURST_W'(1);
      end else begin
        burst_d = burst_q;
      end
    end else if (rd_found_s) begin
      rd_gnt_d[rd_sel_s] = 1'b1;
      bram_addr_d        = rd_addr[rd_sel_s*ADDR_W +: ADDR_W];
      rr_d               = (rd_sel_s == N_RD - 1) ? '0 : PTR_W'(rd_sel_s + 1);
      burst_d            = '0;
    end else begin
      burst_d = '0;
    end
    // The frame strobe overrides the pointer advance but never suppresses the grant.
    if (frame_stb) begin
      rr_d = '0;
    end else begin
      rr_d = rr_d;
    end
  end

  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_gnt_q    <= '0;
      rd_valid_q  <= '0;
      rd_hold_q   <= '0;
      wr_ack_q    <= 1'b0;
      bram_addr_q <= '0;
      bram_we_q   <= 1'b0;
      bram_din_q  <= '0;
      rr_q        <= '0;
      burst_q     <= '0;
    end else begin
      rd_gnt_q    <= rd_gnt_d;
      rd_valid_q  <= rd_gnt_q;
      rd_hold_q   <= (|rd_valid_q) ? bram_dout : rd_hold_q;
      wr_ack_q    <= wr_ack_d;
      bram_addr_q <= bram_addr_d;
      bram_we_q   <= bram_we_d;
      bram_din_q  <= bram_din_d;
      rr_q        <= rr_d;
      burst_q     <= burst_d;
    end
  end

  // BRAM output only becomes valid in the rd_valid cycle, so it is passed straight through then.
  assign rd_data   = (|rd_valid_q) ? bram_dout : rd_hold_q;
  assign rd_gnt    = rd_gnt_q;
  assign rd_valid  = rd_valid_q;
  assign wr_ack    = wr_ack_q;
  assign bram_addr = bram_addr_q;
  assign bram_we   = bram_we_q;
  assign bram_din  = bram_din_q;

endmodule
